ahb_lite_slave_mem: RTL and testbench

AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

---
 rtl/ahb_lite_slave_mem.sv | 207 ++++++++++++++++++++
 tb/tb_ahb_lite_slave_mem.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by a DEPTH-word register memory with optional wait states.
// Define AHB_SLAVE_BYTE_LANE_EN to make byte/halfword writes update only their byte lanes.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_lite_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [`BUS_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [`BUS_WIDTH-1:0] HWDATA,
  output logic [`BUS_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [1:0]            dbg_state_o
);

  localparam int BW = `BUS_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int NB = BW / 8;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Handshake: an address phase is taken only on a clock edge where HSEL, HREADY
  // and our own HREADYOUT are all high with HTRANS NONSEQ/SEQ; the matching data
  // phase completes on the first later edge where HREADYOUT is high.

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            dph_q, dph_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      lo_q, lo_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   mem_q [DEPTH];

  logic            trans_active;
  logic            accept;
  logic            addr_err;
  logic            mem_we;
  logic [NB-1:0]   strb;
  state_t          launch_state;

  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign accept       = HSEL && HREADY && HREADYOUT && trans_active;

  assign addr_err = (HADDR[BW-1:AW+2] != '0)
                 || (HSIZE > SIZE_WORD)
                 || ((HSIZE == SIZE_HALF) && HADDR[0])
                 || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));

  // State after a completion point: either a newly accepted transfer or back to idle.
  always_comb begin
    launch_state = ST_IDLE;
    if (accept) begin
      if (addr_err)             launch_state = ST_ERR1;
      else if (WAIT_STATES > 0) launch_state = ST_WAIT;
      else                      launch_state = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dph_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
      write_q <= write_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = launch_state;
      ST_WAIT: state_d = (cnt_q == 3'd0) ? launch_state : ST_WAIT;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = launch_state;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    dph_d   = dph_q;
    write_d = write_q;
    size_d  = size_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    if (accept && !addr_err) begin
      cnt_d = 3'(WAIT_STATES);
    end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
    if (HREADYOUT) begin
      dph_d = accept && !addr_err;
    end
    if (accept) begin
      write_d = HWRITE;
      size_d  = HSIZE;
      lo_d    = HADDR[1:0];
      idx_d   = HADDR[AW+1:2];
    end
  end

  // Output logic
  always_comb begin
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    dbg_state_o = state_q;
    unique case (state_q)
      ST_WAIT: HREADYOUT = (cnt_q == 3'd0);
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
    if (dph_q && !write_q) begin
      HRDATA = mem_q[idx_q];
    end
  end

`ifdef AHB_SLAVE_BYTE_LANE_EN
  // Little-endian lane select from the captured size and low address bits.
  always_comb begin
    strb = '0;
    unique case (size_q)
      SIZE_BYTE: strb[lo_q] = 1'b1;
      SIZE_HALF: begin
        strb[{lo_q[1], 1'b0}] = 1'b1;
        strb[{lo_q[1], 1'b1}] = 1'b1;
      end
      default: strb = '1;
    endcase
  end
`else
  assign strb = '1;
  logic unused_lane;
  assign unused_lane = ^{size_q, lo_q};
`endif

  // A reset landing on the completing edge aborts the write.
  assign mem_we = dph_q && write_q && HREADYOUT && !HRESET;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

  a_err_pair: assert property (@(posedge HCLK) disable iff (HRESET)
    (state_q == ST_ERR1) |=> (state_q == ST_ERR2));

  a_wait_count: assert property (@(posedge HCLK) disable iff (HRESET)
    ((state_q == ST_WAIT) && (cnt_q != 3'd0)) |=>
      ((state_q == ST_WAIT) && (cnt_q == $past(cnt_q) - 3'd1)));

  a_err_no_data: assert property (@(posedge HCLK) disable iff (HRESET)
    (state_q == ST_ERR1) |-> !dph_q);

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench for ahb_lite_slave_mem: one zero-wait instance and one
// two-wait-state instance, each selected on its own HSEL line.

module tb_ahb_lite_slave_mem;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel2, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata2;
  logic        rdy0, rdy2, resp0, resp2;
  logic [1:0]  st0, st2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] err_addr [6] = '{32'h0000_0040, 32'h0000_007C, 32'h8000_0000,
                                32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
  logic [2:0]  err_size [6] = '{SZ_W, SZ_W, SZ_W, SZ_W, SZ_H, 3'b011};

  always #5 clk = ~clk;

  ahb_lite_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(rdy0), .HWDATA(hwdata), .HRDATA(hrdata0),
    .HREADYOUT(rdy0), .HRESP(resp0), .dbg_state_o(st0)
  );

  ahb_lite_slave_mem #(.DEPTH(16), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HMASTLOCK(hmastlock), .HREADY(rdy2), .HWDATA(hwdata), .HRDATA(hrdata2),
    .HREADYOUT(rdy2), .HRESP(resp2), .dbg_state_o(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input int d, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [1:0] tr);
    hsel0  = (d == 0);
    hsel2  = (d == 2);
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
  endtask

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = T_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = SZ_W;
  endtask

  function automatic logic ready_of(input int d);
    return (d == 2) ? rdy2 : rdy0;
  endfunction

  function automatic logic resp_of(input int d);
    return (d == 2) ? resp2 : resp0;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 2) ? hrdata2 : hrdata0;
  endfunction

  // Single non-pipelined transfer; reports read data, low-ready cycles and any ERROR seen.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int low, output logic err);
    addr_ph(d, a, w, sz, T_NONSEQ);
    tick();
    bus_idle();
    hwdata = wdata;
    low = 0;
    err = 1'b0;
    while (ready_of(d) !== 1'b1 && low < 32) begin
      low++;
      err |= resp_of(d);
      tick();
    end
    err |= resp_of(d);
    rdata = rdata_of(d);
    tick();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    bus_idle();
    hwdata = '0;
    repeat (3) tick();
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rst_ready0 got=%0h exp=1", rdy0); end
    n_vec++; if (resp0 !== 1'b0) begin n_err++; $display("FAIL rst_resp0 got=%0h exp=0", resp0); end
    n_vec++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL rst_rdata0 got=%h exp=0", hrdata0); end
    n_vec++; if (st0 !== 2'd0) begin n_err++; $display("FAIL rst_state0 got=%0d exp=0", st0); end
    n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL rst_ready2 got=%0h exp=1", rdy2); end
    n_vec++; if (resp2 !== 1'b0) begin n_err++; $display("FAIL rst_resp2 got=%0h exp=0", resp2); end
    n_vec++; if (hrdata2 !== 32'h0) begin n_err++; $display("FAIL rst_rdata2 got=%h exp=0", hrdata2); end
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    addr_ph(0, 32'h08, 1'b1, SZ_W, T_NONSEQ);
    tick();
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL wr_ready got=%0h exp=1", rdy0); end
    hwdata = 32'hDEAD_BEEF;
    addr_ph(0, 32'h08, 1'b0, SZ_W, T_NONSEQ);
    tick();
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rd_ready got=%0h exp=1", rdy0); end
    n_vec++; if (resp0 !== 1'b0) begin n_err++; $display("FAIL rd_resp got=%0h exp=0", resp0); end
    n_vec++; if (hrdata0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef", hrdata0); end
    bus_idle();
    tick();
    n_vec++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL rd_data_after got=%h exp=0", hrdata0); end
  endtask

  task automatic test_idle_busy();
    addr_ph(0, 32'h00, 1'b1, SZ_W, T_NONSEQ);
    tick();
    hwdata = 32'hCAFE_F00D;
    addr_ph(0, 32'h00, 1'b0, SZ_W, T_NONSEQ);
    tick();
    n_vec++; if (hrdata0 !== 32'hCAFE_F00D) begin n_err++; $display("FAIL pipe_rd got=%h exp=cafef00d", hrdata0); end
    hwdata = 32'h0BAD_0BAD;
    addr_ph(0, 32'h00, 1'b1, SZ_W, T_BUSY);
    tick();
    n_vec++; if ({rdy0, resp0} !== 2'b10) begin n_err++; $display("FAIL busy_resp got=%b exp=10", {rdy0, resp0}); end
    n_vec++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL busy_rdata got=%h exp=0", hrdata0); end
    addr_ph(0, 32'h00, 1'b1, SZ_W, T_IDLE);
    tick();
    n_vec++; if ({rdy0, resp0} !== 2'b10) begin n_err++; $display("FAIL idle_resp got=%b exp=10", {rdy0, resp0}); end
    addr_ph(0, 32'h00, 1'b0, SZ_W, T_NONSEQ);
    tick();
    n_vec++; if (hrdata0 !== 32'hCAFE_F00D) begin n_err++; $display("FAIL no_busy_write got=%h exp=cafef00d", hrdata0); end
    bus_idle();
    tick();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int          low;
    logic        er;
    xfer(2, 32'h04, 1'b1, SZ_W, 32'h55AA_1234, rd, low, er);
    n_vec++; if (low !== 2) begin n_err++; $display("FAIL ws_wr_low got=%0d exp=2", low); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL ws_wr_err got=%0h exp=0", er); end
    addr_ph(2, 32'h04, 1'b0, SZ_W, T_NONSEQ);
    tick();
    bus_idle();
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL ws_low%0d got=%0h exp=0", i, rdy2); end
      n_vec++; if (hrdata2 !== 32'h55AA_1234) begin n_err++; $display("FAIL ws_data_wait%0d got=%h exp=55aa1234", i, hrdata2); end
      tick();
    end
    n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL ws_high got=%0h exp=1", rdy2); end
    n_vec++; if (hrdata2 !== 32'h55AA_1234) begin n_err++; $display("FAIL ws_data got=%h exp=55aa1234", hrdata2); end
    n_vec++; if (resp2 !== 1'b0) begin n_err++; $display("FAIL ws_resp got=%0h exp=0", resp2); end
    tick();
    n_vec++; if (hrdata2 !== 32'h0) begin n_err++; $display("FAIL ws_data_after got=%h exp=0", hrdata2); end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    int          low;
    logic        er;
    xfer(0, 32'h00, 1'b1, SZ_W, 32'h0A0B_0C0D, rd, low, er);
    addr_ph(0, 32'h40, 1'b0, SZ_W, T_NONSEQ);
    tick();
    bus_idle();
    n_vec++; if ({rdy0, resp0} !== 2'b01) begin n_err++; $display("FAIL err1 got=%b exp=01", {rdy0, resp0}); end
    n_vec++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL err1_rdata got=%h exp=0", hrdata0); end
    tick();
    n_vec++; if ({rdy0, resp0} !== 2'b11) begin n_err++; $display("FAIL err2 got=%b exp=11", {rdy0, resp0}); end
    tick();
    n_vec++; if ({rdy0, resp0} !== 2'b10) begin n_err++; $display("FAIL err_done got=%b exp=10", {rdy0, resp0}); end
    for (int i = 0; i < 6; i++) begin
      xfer(0, err_addr[i], 1'b1, err_size[i], 32'hFFFF_FFFF, rd, low, er);
      n_vec++; if (low !== 1 || er !== 1'b1) begin n_err++; $display("FAIL err_case%0d got=low%0d/err%0h exp=low1/err1", i, low, er); end
    end
    xfer(0, 32'h02, 1'b0, SZ_H, 32'h0, rd, low, er);
    n_vec++; if (low !== 0 || er !== 1'b0 || rd !== 32'h0A0B_0C0D) begin n_err++; $display("FAIL half_ok got=%h/low%0d/err%0h exp=0a0b0c0d/low0/err0", rd, low, er); end
    xfer(0, 32'h00, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (rd !== 32'h0A0B_0C0D) begin n_err++; $display("FAIL err_mem_kept got=%h exp=0a0b0c0d", rd); end
    xfer(0, 32'h3C, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (low !== 0 || er !== 1'b0) begin n_err++; $display("FAIL top_addr got=low%0d/err%0h exp=low0/err0", low, er); end
    xfer(2, 32'h40, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (low !== 1 || er !== 1'b1) begin n_err++; $display("FAIL err_no_ws got=low%0d/err%0h exp=low1/err1", low, er); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    logic [31:0] exp_b, exp_h;
    int          low;
    logic        er;
`ifdef AHB_SLAVE_BYTE_LANE_EN
    exp_b = 32'h1122_AA44;
    exp_h = 32'hBEEF_AA44;
`else
    exp_b = 32'h5566_AA77;
    exp_h = 32'hBEEF_9999;
`endif
    xfer(0, 32'h0C, 1'b1, SZ_W, 32'h1122_3344, rd, low, er);
    xfer(0, 32'h0D, 1'b1, SZ_B, 32'h5566_AA77, rd, low, er);
    xfer(0, 32'h0C, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (rd !== exp_b) begin n_err++; $display("FAIL byte_lane got=%h exp=%h", rd, exp_b); end
    xfer(0, 32'h0E, 1'b1, SZ_H, 32'hBEEF_9999, rd, low, er);
    xfer(0, 32'h0C, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (rd !== exp_h) begin n_err++; $display("FAIL half_lane got=%h exp=%h", rd, exp_h); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd;
    int          low;
    logic        er;
    xfer(2, 32'h14, 1'b1, SZ_W, 32'h0102_0304, rd, low, er);
    addr_ph(2, 32'h14, 1'b1, SZ_W, T_NONSEQ);
    tick();
    bus_idle();
    hwdata = 32'hFFFF_0000;
    n_vec++; if (rdy2 !== 1'b0) begin n_err++; $display("FAIL rw_in_wait got=%0h exp=0", rdy2); end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    n_vec++; if ({rdy2, resp2} !== 2'b10) begin n_err++; $display("FAIL rw_after got=%b exp=10", {rdy2, resp2}); end
    n_vec++; if (st2 !== 2'd0) begin n_err++; $display("FAIL rw_state got=%0d exp=0", st2); end
    xfer(2, 32'h14, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (rd !== 32'h0102_0304) begin n_err++; $display("FAIL rw_mem_kept got=%h exp=01020304", rd); end
    xfer(0, 32'h08, 1'b0, SZ_W, 32'h0, rd, low, er);
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_survives_reset got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int low;
    addr_ph(2, 32'h18, 1'b1, SZ_W, T_NONSEQ);
    tick();
    hwdata = 32'h89AB_CDEF;
    addr_ph(2, 32'h18, 1'b0, SZ_W, T_NONSEQ);
    low = 0;
    while (rdy2 !== 1'b1 && low < 16) begin low++; tick(); end
    n_vec++; if (low !== 2) begin n_err++; $display("FAIL b2b_wr_low got=%0d exp=2", low); end
    tick();
    bus_idle();
    low = 0;
    while (rdy2 !== 1'b1 && low < 16) begin low++; tick(); end
    n_vec++; if (low !== 2) begin n_err++; $display("FAIL b2b_rd_low got=%0d exp=2", low); end
    n_vec++; if (hrdata2 !== 32'h89AB_CDEF) begin n_err++; $display("FAIL b2b_rd_data got=%h exp=89abcdef", hrdata2); end
    tick();
  endtask

  initial begin
    hburst    = 3'b011;
    hprot     = 4'b0011;
    hmastlock = 1'b1;
    hwdata    = '0;
    hreset    = 1'b1;
    bus_idle();
    test_reset();
    test_write_read();
    test_idle_busy();
    test_wait_states();
    test_error();
    test_byte_lane();
    test_reset_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
